// File: rtl/div16u8_seq.sv
// div16u8_seq: sequential restoring radix-2 unsigned divider, 16-bit dividend
// by 8-bit divisor, one quotient bit per cycle, valid/ready on both sides.
// TRUNC_BITS skips the lowest quotient iterations; skipped bits read as zero.
`timescale 1ns/1ps
module div16u8_seq #(
    parameter int unsigned TRUNC_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    // Index of the last iteration actually performed.
    localparam logic [2:0] LAST_IDX = 3'(TRUNC_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    // Only the low dividend byte is consumed bit by bit; the high byte seeds
    // the partial remainder at accept time.
    logic [7:0]  dvd_lo_r;
    logic [7:0]  dvs_r;
    // Partial remainder is always below the divisor, so 8 bits hold it.
    logic [7:0]  rem_r;
    logic [7:0]  q_r;
    logic [2:0]  idx_r;

    logic [7:0]  quotient_r;
    logic [7:0]  remainder_r;
    logic        dbz_r;
    logic        ovf_r;

    logic        accept_s;
    logic        last_iter_s;
    logic        sub_ok_s;
    logic [8:0]  trial_s;
    logic [7:0]  diff_s;
    logic [7:0]  rem_next_s;
    logic [7:0]  q_next_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial_s    = {rem_r, dvd_lo_r[idx_r]};
        sub_ok_s   = (trial_s >= {1'b0, dvs_r});
        // True difference is < 256 whenever it is used, so 8-bit wrap is exact.
        diff_s     = trial_s[7:0] - dvs_r;
        q_next_s   = q_r;
        if (sub_ok_s) begin
            rem_next_s       = diff_s;
            q_next_s[idx_r]  = 1'b1;
        end else begin
            rem_next_s       = trial_s[7:0];
        end
        last_iter_s = (idx_r == LAST_IDX);
        accept_s    = in_valid && (state_r == IDLE);
    end

    // Next-state decode for the IDLE/CALC/DONE controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if ((divisor == 8'd0) || (dividend[15:8] >= divisor)) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (last_iter_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, iteration datapath and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_lo_r    <= 8'd0;
            dvs_r       <= 8'd0;
            rem_r       <= 8'd0;
            q_r         <= 8'd0;
            idx_r       <= 3'd0;
            quotient_r  <= 8'd0;
            remainder_r <= 8'd0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dvd_lo_r <= dividend[7:0];
                        dvs_r    <= divisor;
                        rem_r    <= dividend[15:8];
                        q_r      <= 8'd0;
                        idx_r    <= 3'd7;
                        if (divisor == 8'd0) begin
                            quotient_r  <= 8'hFF;
                            remainder_r <= dividend[7:0];
                            dbz_r       <= 1'b1;
                            ovf_r       <= 1'b0;
                        end else if (dividend[15:8] >= divisor) begin
                            quotient_r  <= 8'hFF;
                            remainder_r <= 8'h00;
                            dbz_r       <= 1'b0;
                            ovf_r       <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    q_r   <= q_next_s;
                    idx_r <= idx_r - 3'd1;
                    if (last_iter_s) begin
                        // Skipped low quotient bits were cleared at accept.
                        quotient_r  <= q_next_s;
                        remainder_r <= rem_next_s;
                        dbz_r       <= 1'b0;
                        ovf_r       <= 1'b0;
                    end
                end
                DONE: begin
                    // Results are held until the consumer takes them.
                end
                default: begin
                    q_r <= 8'd0;
                end
            endcase
        end
    end

    // Handshake flags come straight from the state register; in_ready is
    // additionally held low while reset is asserted.
    assign in_ready    = (state_r == IDLE) && !rst;
    assign out_valid   = (state_r == DONE);
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_div16u8_seq.sv
// Bench for div16u8_seq: an exact instance and a TRUNC_BITS=2 instance share
// the input side; results are compared against tables and a division model.
`timescale 1ns/1ps
module tb_div16u8_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [7:0]  divisor = 8'd0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, dbz0, ovf0;
    logic [7:0]  quotient0, remainder0;
    logic        in_ready2, out_valid2, dbz2, ovf2;
    logic [7:0]  quotient2, remainder2;

    int total = 0;
    int bad = 0;

    // Results captured at the first cycle each instance shows out_valid.
    logic [7:0] cq0, cr0, cq2, cr2;
    logic       cz0, co0, cz2, co2;
    int         lat0, lat2;

    div16u8_seq #(.TRUNC_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid0),
        .out_ready(out_ready), .quotient(quotient0), .remainder(remainder0),
        .div_by_zero(dbz0), .overflow(ovf0)
    );

    div16u8_seq #(.TRUNC_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid2),
        .out_ready(out_ready), .quotient(quotient2), .remainder(remainder2),
        .div_by_zero(dbz2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q0;
        logic [7:0]  r0;
        logic [7:0]  q2;
        logic [7:0]  r2;
        logic        z;
        logic        o;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division on the (optionally shifted) dividend.
    // Special cases report valid right after the accept edge (0 extra edges);
    // normal divides take 8-t further edges.
    task automatic model(input logic [15:0] a, input logic [7:0] b, input int t,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic z, output logic o, output int lat);
        int unsigned ua, ub, sa;
        ua = a;
        ub = b;
        if (ub == 0) begin
            q = 8'hFF; r = a[7:0]; z = 1'b1; o = 1'b0; lat = 0;
        end else if (ua / ub > 255) begin
            q = 8'hFF; r = 8'h00; z = 1'b0; o = 1'b1; lat = 0;
        end else begin
            sa = ua >> t;
            q = 8'((sa / ub) << t);
            r = 8'(sa % ub);
            z = 1'b0; o = 1'b0; lat = 8 - t;
        end
    endtask

    // Wait (bounded) until both instances show out_valid, capturing results.
    // Entered #1 after the accept edge.
    task automatic wait_results();
        bit g0, g2;
        g0 = 1'b0; g2 = 1'b0; lat0 = -1; lat2 = -1;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (!g0 && out_valid0) begin
                g0 = 1'b1; lat0 = c;
                cq0 = quotient0; cr0 = remainder0; cz0 = dbz0; co0 = ovf0;
            end
            if (!g2 && out_valid2) begin
                g2 = 1'b1; lat2 = c;
                cq2 = quotient2; cr2 = remainder2; cz2 = dbz2; co2 = ovf2;
            end
            if (g0 && g2) break;
        end
    endtask

    // Present operands, accept on one edge, then scramble the inputs.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        dividend = a; divisor = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor = 8'($urandom);
    endtask

    // Complete the output handshake; both instances must be idle afterwards.
    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ovalid_after_pop", int'(out_valid0), 0);
        chk("iready0_after_pop", int'(in_ready0), 1);
        chk("iready2_after_pop", int'(in_ready2), 1);
    endtask

    task automatic check_model(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic [7:0] q, r;
        logic z, o;
        int lat;
        model(a, b, 0, q, r, z, o, lat);
        chk({tag, "_q0"}, int'(cq0), int'(q));
        chk({tag, "_r0"}, int'(cr0), int'(r));
        chk({tag, "_z0"}, int'(cz0), int'(z));
        chk({tag, "_o0"}, int'(co0), int'(o));
        chk({tag, "_lat0"}, lat0, lat);
        model(a, b, 2, q, r, z, o, lat);
        chk({tag, "_q2"}, int'(cq2), int'(q));
        chk({tag, "_r2"}, int'(cr2), int'(r));
        chk({tag, "_z2"}, int'(cz2), int'(z));
        chk({tag, "_o2"}, int'(co2), int'(o));
        chk({tag, "_lat2"}, lat2, lat);
    endtask

    initial begin
        vec_t vecs[7];
        logic [7:0] hq, hr;
        logic [15:0] pa;
        logic [7:0] pb, ra, rb;

        vecs[0] = '{16'h3A5F, 8'h5B, 8'hA4, 8'h13, 8'hA4, 8'h04, 1'b0, 1'b0};
        vecs[1] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 8'hFC, 8'hBF, 1'b0, 1'b0};
        vecs[2] = '{16'h12AB, 8'h00, 8'hFF, 8'hAB, 8'hFF, 8'hAB, 1'b1, 1'b0};
        vecs[3] = '{16'h5000, 8'h40, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 8'h47, 8'h41, 8'h2D, 8'h40, 8'h1D, 1'b0, 1'b0};
        vecs[5] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 8'hFC, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

        // Reset state
        #2;
        chk("rst_iready", int'(in_ready0), 0);
        chk("rst_ovalid", int'(out_valid0), 0);
        chk("rst_quot", int'(quotient0), 0);
        chk("rst_rem", int'(remainder0), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_iready", int'(in_ready0), 1);
        chk("rel_iready2", int'(in_ready2), 1);

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start_op(vecs[i].a, vecs[i].b);
            wait_results();
            chk("tbl_q0", int'(cq0), int'(vecs[i].q0));
            chk("tbl_r0", int'(cr0), int'(vecs[i].r0));
            chk("tbl_q2", int'(cq2), int'(vecs[i].q2));
            chk("tbl_r2", int'(cr2), int'(vecs[i].r2));
            chk("tbl_z0", int'(cz0), int'(vecs[i].z));
            chk("tbl_o0", int'(co0), int'(vecs[i].o));
            chk("tbl_z2", int'(cz2), int'(vecs[i].z));
            chk("tbl_o2", int'(co2), int'(vecs[i].o));
            chk("tbl_lat0", lat0, (vecs[i].z || vecs[i].o) ? 0 : 8);
            chk("tbl_lat2", lat2, (vecs[i].z || vecs[i].o) ? 0 : 6);
            pop();
        end

        // Backpressure: hold results, ignore in_valid while in DONE
        @(negedge clk);
        start_op(16'h3A5F, 8'h5B);
        wait_results();
        hq = quotient0; hr = remainder0;
        dividend = 16'h0100; divisor = 8'h03;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 2);
            @(posedge clk); #1;
            chk("bp_ovalid", int'(out_valid0), 1);
            chk("bp_iready", int'(in_ready0), 0);
            chk("bp_quot", int'(quotient0), int'(hq));
            chk("bp_rem", int'(remainder0), int'(hr));
        end
        // Handshake with a new operand pending; it is taken one edge later.
        dividend = 16'h0C35; divisor = 8'h1D;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_pop_ovalid", int'(out_valid0), 0);
        chk("bp_pop_iready", int'(in_ready0), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_acc_iready", int'(in_ready0), 0);
        wait_results();
        check_model("bp_pend", 16'h0C35, 8'h1D);
        pop();

        // Reset asserted during the 4th CALC cycle
        @(negedge clk);
        start_op(16'h3A5F, 8'h5B);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ovalid", int'(out_valid0), 0);
        chk("mid_rst_iready", int'(in_ready0), 0);
        chk("mid_rst_quot", int'(quotient0), 0);
        chk("mid_rst_rem", int'(remainder0), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("post_rst_ovalid", int'(out_valid0), 0);
            chk("post_rst_iready", int'(in_ready0), 1);
        end
        @(negedge clk);
        start_op(16'h1234, 8'h47);
        wait_results();
        check_model("post_rst", 16'h1234, 8'h47);
        pop();

        // Random products: dividing A*B by B recovers A exactly
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            pa = 16'(ra) * 16'(rb);
            @(negedge clk);
            start_op(pa, rb);
            wait_results();
            chk("prod_q", int'(cq0), int'(ra));
            chk("prod_r", int'(cr0), 0);
            check_model("prod", pa, rb);
            pop();
        end

        // Random operands, biased toward in-range quotients
        for (int i = 0; i < 30; i++) begin
            pb = 8'($urandom_range(0, 255));
            if (($urandom_range(0, 3) != 0) && (pb != 8'd0)) begin
                pa = {8'($urandom_range(0, int'(pb) - 1)), 8'($urandom)};
            end else begin
                pa = 16'($urandom);
            end
            @(negedge clk);
            start_op(pa, pb);
            wait_results();
            check_model("rand", pa, pb);
            pop();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
